// File: rtl/isr_level_decoder.sv
// Interrupt acknowledge path: INT generation, two-pulse INTA handshake, ISR set/clear and vector drive.
// Optional build macro AUTO_EOI_EN clears the serviced ISR bit at the end of the second INTA pulse.
module isr_level_decoder #(
  parameter int VEC_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_req,
  input  logic [2:0]       level_in,
  input  logic             inta_n,
  input  logic             eoi_valid,
  input  logic             eoi_specific,
  input  logic [2:0]       eoi_level,
  input  logic [VEC_W-1:0] vector_base,
  output logic             int_out,
  output logic [7:0]       isr,
  output logic [7:0]       data_out,
  output logic             data_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2,
    ACK2 = 2'd3
  } state_t;

  state_t     state, state_next;
  logic       inta_q;
  logic [2:0] lvl_q, lvl_next;
  logic       int_next, data_oe_next;
  logic [7:0] data_out_next;
  logic [7:0] set_mask, clr_mask;
  logic       inta_fall, inta_rise;
  logic       isr_any;
  logic [2:0] isr_top;
  logic       qualified;
`ifdef AUTO_EOI_EN
  logic       spur_q, spur_next;
`endif

  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  // Highest in-service level; ascending scan so the last hit wins.
  always_comb begin
    isr_any = 1'b0;
    isr_top = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (isr[i]) begin
        isr_any = 1'b1;
        isr_top = 3'(i);
      end
    end
  end

  assign qualified = int_req && (!isr_any || (level_in > isr_top));

  always_comb begin
    state_next    = state;
    lvl_next      = lvl_q;
    int_next      = int_out;
    data_oe_next  = data_oe;
    data_out_next = data_out;
    set_mask      = 8'h00;
    clr_mask      = 8'h00;
`ifdef AUTO_EOI_EN
    spur_next     = spur_q;
`endif

    if (eoi_valid) begin
      if (eoi_specific)
        clr_mask = 8'b1 << eoi_level;
      else if (isr_any)
        clr_mask = 8'b1 << isr_top;
    end

    case (state)
      IDLE: begin
        if (qualified) begin
          state_next = REQ;
          int_next   = 1'b1;
        end
      end
      REQ: begin
        if (inta_fall) begin
          state_next = ACK1;
          int_next   = 1'b0;
          if (int_req) begin
            lvl_next = level_in;
            set_mask = 8'b1 << level_in;
          end else begin
            lvl_next = 3'd7;
          end
`ifdef AUTO_EOI_EN
          spur_next = ~int_req;
`endif
        end
      end
      ACK1: begin
        if (inta_fall) begin
          state_next    = ACK2;
          data_out_next = {vector_base, lvl_q};
          data_oe_next  = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_next   = IDLE;
          data_oe_next = 1'b0;
`ifdef AUTO_EOI_EN
          if (!spur_q)
            clr_mask = clr_mask | (8'b1 << lvl_q);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inta_q   <= 1'b1;
      lvl_q    <= 3'd0;
      int_out  <= 1'b0;
      isr      <= 8'h00;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
`ifdef AUTO_EOI_EN
      spur_q   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      inta_q   <= inta_n;
      lvl_q    <= lvl_next;
      int_out  <= int_next;
      // Set wins over a clear of the same bit in one cycle.
      isr      <= (isr & ~clr_mask) | set_mask;
      data_out <= data_out_next;
      data_oe  <= data_oe_next;
`ifdef AUTO_EOI_EN
      spur_q   <= spur_next;
`endif
    end
  end

endmodule

// File: tb/tb_isr_level_decoder.sv
// Scoreboard bench for isr_level_decoder (default build): expectations queued per step, drained after the edge.
module tb_isr_level_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       int_req = 1'b0;
  logic [2:0] level_in = 3'd0;
  logic       inta_n = 1'b1;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic [4:0] vector_base = 5'b01000;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_oe;

  localparam int S_INT = 0, S_ISR = 1, S_DATA = 2, S_OE = 3;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  isr_level_decoder #(.VEC_W(5)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .level_in(level_in), .inta_n(inta_n),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .vector_base(vector_base), .int_out(int_out), .isr(isr), .data_out(data_out),
    .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic want(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      S_INT:   return {7'd0, int_out};
      S_ISR:   return isr;
      S_DATA:  return data_out;
      default: return {7'd0, data_oe};
    endcase
  endfunction

  // One clock edge, then compare everything queued for it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    want("rst_int", S_INT, 8'h00); want("rst_isr", S_ISR, 8'h00);
    want("rst_data", S_DATA, 8'h00); want("rst_oe", S_OE, 8'h00);
    step();
    rst = 1'b0;
    step();

    // Normal acknowledge at level 3
    int_req = 1'b1; level_in = 3'd3;
    want("req3_int", S_INT, 8'h01);
    step();
    inta_n = 1'b0;
    want("ack1_isr", S_ISR, 8'h08); want("ack1_int", S_INT, 8'h00);
    step();
    int_req = 1'b0; inta_n = 1'b1;
    want("gap_oe", S_OE, 8'h00);
    step();
    inta_n = 1'b0;
    want("ack2_data", S_DATA, 8'h43); want("ack2_oe", S_OE, 8'h01);
    step();
    want("ack2_hold_oe", S_OE, 8'h01);
    step();
    inta_n = 1'b1;
    want("rise_oe", S_OE, 8'h00);
    step();

    // Nesting: level 2 held off, level 6 accepted
    int_req = 1'b1; level_in = 3'd2;
    want("nest_lo_int_a", S_INT, 8'h00);
    step();
    want("nest_lo_int_b", S_INT, 8'h00);
    step();
    level_in = 3'd6;
    want("nest_hi_int", S_INT, 8'h01);
    step();
    inta_n = 1'b0;
    want("nest_isr", S_ISR, 8'h48);
    step();
    int_req = 1'b0; inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    want("nest_data", S_DATA, 8'h46); want("nest_oe", S_OE, 8'h01);
    step();
    inta_n = 1'b1;
    want("nest_rise_oe", S_OE, 8'h00);
    step();

    // EOI handling
    eoi_valid = 1'b1; eoi_specific = 1'b0;
    want("nseoi_isr", S_ISR, 8'h08);
    step();
    eoi_specific = 1'b1; eoi_level = 3'd3;
    want("seoi_isr", S_ISR, 8'h00);
    step();
    eoi_specific = 1'b0;
    want("nseoi_empty_isr", S_ISR, 8'h00);
    step();
    eoi_valid = 1'b0;
    step();

    // IDLE ignores INTA
    inta_n = 1'b0;
    want("idle_inta_int", S_INT, 8'h00); want("idle_inta_oe", S_OE, 8'h00);
    step();
    inta_n = 1'b1;
    step();

    // Spurious: request withdrawn before first INTA
    int_req = 1'b1; level_in = 3'd5;
    want("spur_int", S_INT, 8'h01);
    step();
    int_req = 1'b0;
    want("spur_int_hold", S_INT, 8'h01);
    step();
    inta_n = 1'b0;
    want("spur_isr", S_ISR, 8'h00); want("spur_int_clr", S_INT, 8'h00);
    step();
    inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    want("spur_data", S_DATA, 8'h47); want("spur_oe", S_OE, 8'h01);
    step();
    inta_n = 1'b1;
    want("spur_rise_oe", S_OE, 8'h00);
    step();

    // Set/clear collision on level 5, then reset while in ACK1
    int_req = 1'b1; level_in = 3'd5;
    want("coll_int", S_INT, 8'h01);
    step();
    inta_n = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd5;
    want("coll_isr", S_ISR, 8'h20);
    step();
    int_req = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; inta_n = 1'b1;
    step();
    rst = 1'b1;
    want("mrst_int", S_INT, 8'h00); want("mrst_isr", S_ISR, 8'h00);
    want("mrst_data", S_DATA, 8'h00); want("mrst_oe", S_OE, 8'h00);
    step();
    rst = 1'b0;
    inta_n = 1'b0;
    want("post_rst_oe_a", S_OE, 8'h00); want("post_rst_int", S_INT, 8'h00);
    step();
    inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    want("post_rst_oe_b", S_OE, 8'h00); want("post_rst_data", S_DATA, 8'h00);
    step();
    inta_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
